// File: rtl/alu_bcd_datapath.sv
// rtl/alu_bcd_datapath.sv - 8-bit 6502-style ALU slice with operand latches and decimal adjust
// Optional feature macro: CMOS_BITMASK_EN (a_src = 3 loads 1 << ir_bits into the A latch)
module alu_bcd_datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic [1:0] a_src,
  input  logic [7:0] a_in,
  input  logic       b_load,
  input  logic [7:0] b_in,
  input  logic [1:0] c_sel,
  input  logic       p_carry,
  input  logic [2:0] ir_bits,
  input  logic [3:0] alu_op,
  input  logic       dec_en,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic       half_carry_out,
  output logic       overflow_out,
  output logic [7:0] adj_out,
  output logic [7:0] a_reg,
  output logic [7:0] sign_fill,
  output logic       page_cross
);

  logic [7:0] b_reg;
  logic       carry_last;
  logic       cin;
  logic [7:0] a_next;

  logic       dec_add;
  logic       dec_sub;
  logic [4:0] lo_sum;
  logic [4:0] hi_sum;
  logic       lo_carry;
  logic       hi_carry;
  logic [3:0] adj_lo;
  logic [3:0] adj_hi;

`ifdef CMOS_BITMASK_EN
  logic [7:0] bit_mask;
  assign bit_mask = 8'h01 << ir_bits;
`else
  // Decoder is not built; ir_bits has no load in this build.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_bits;
`endif

  // Carry-in source selection
  always_comb begin
    case (c_sel)
      2'd0:    cin = 1'b0;
      2'd1:    cin = 1'b1;
      2'd2:    cin = p_carry;
      default: cin = carry_last;
    endcase
  end

  // A latch input mux; a_src = 0 never loads so its value is irrelevant
  always_comb begin
    case (a_src)
      2'd1:    a_next = a_in;
`ifdef CMOS_BITMASK_EN
      2'd3:    a_next = bit_mask;
`endif
      default: a_next = 8'h00;
    endcase
  end

  // Operand latches and the carry history used by c_sel = 3
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= 8'h00;
      b_reg      <= 8'h00;
      carry_last <= 1'b0;
    end else begin
      if (ready && (a_src != 2'd0)) a_reg <= a_next;
      if (ready && b_load)          b_reg <= b_in;
      carry_last <= carry_out;
    end
  end

  // Decimal behaviour only applies to ADC; SBC always uses binary carries
  assign dec_add = dec_en && (alu_op == 4'd0);
  assign dec_sub = dec_en && (alu_op == 4'd1);

  // Nibble-split adder: decimal add redefines the digit carries as "sum > 9"
  assign lo_sum   = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0000, cin};
  assign lo_carry = dec_add ? (lo_sum > 5'd9) : lo_sum[4];
  assign hi_sum   = {1'b0, a_reg[7:4]} + {1'b0, b_reg[7:4]} + {4'b0000, lo_carry};
  assign hi_carry = dec_add ? (hi_sum > 5'd9) : hi_sum[4];

  // Operation select; flags default to zero for the logic and pass ops
  always_comb begin
    alu_out        = 8'h00;
    carry_out      = 1'b0;
    half_carry_out = 1'b0;
    overflow_out   = 1'b0;
    case (alu_op)
      4'd0, 4'd1: begin
        alu_out        = {hi_sum[3:0], lo_sum[3:0]};
        carry_out      = hi_carry;
        half_carry_out = lo_carry;
        overflow_out   = ~(a_reg[7] ^ b_reg[7]) & (a_reg[7] ^ hi_sum[3]);
      end
      4'd2: alu_out = a_reg & b_reg;
      4'd3: alu_out = a_reg | b_reg;
      4'd4: alu_out = a_reg ^ b_reg;
      4'd5: begin
        alu_out   = {cin, a_reg[7:1]};
        carry_out = a_reg[0];
      end
      4'd6: alu_out = a_reg;
      4'd7: alu_out = b_reg;
      default: begin
        alu_out   = 8'h00;
        carry_out = 1'b0;
      end
    endcase
  end

  // Nibble-wise decimal correction, each nibble wraps mod 16 independently
  always_comb begin
    adj_lo = alu_out[3:0];
    adj_hi = alu_out[7:4];
    if (dec_add) begin
      if (half_carry_out) adj_lo = alu_out[3:0] + 4'd6;
      if (carry_out)      adj_hi = alu_out[7:4] + 4'd6;
    end else if (dec_sub) begin
      if (!half_carry_out) adj_lo = alu_out[3:0] - 4'd6;
      if (!carry_out)      adj_hi = alu_out[7:4] - 4'd6;
    end
  end

  assign adj_out    = {adj_hi, adj_lo};
  assign sign_fill  = {8{a_reg[7]}};
  assign page_cross = carry_out ^ a_reg[7];

endmodule

// File: tb/tb_alu_bcd_datapath.sv
// tb/tb_alu_bcd_datapath.sv - directed self-checking bench for alu_bcd_datapath
module tb_alu_bcd_datapath;

  logic       clk;
  logic       reset;
  logic       ready;
  logic [1:0] a_src;
  logic [7:0] a_in;
  logic       b_load;
  logic [7:0] b_in;
  logic [1:0] c_sel;
  logic       p_carry;
  logic [2:0] ir_bits;
  logic [3:0] alu_op;
  logic       dec_en;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       half_carry_out;
  logic       overflow_out;
  logic [7:0] adj_out;
  logic [7:0] a_reg;
  logic [7:0] sign_fill;
  logic       page_cross;

  int vectors = 0;
  int miscompares = 0;

  int m_a = 0;
  int m_b = 0;
  int m_cl = 0;

  alu_bcd_datapath dut (
    .clk(clk), .reset(reset), .ready(ready), .a_src(a_src), .a_in(a_in),
    .b_load(b_load), .b_in(b_in), .c_sel(c_sel), .p_carry(p_carry),
    .ir_bits(ir_bits), .alu_op(alu_op), .dec_en(dec_en), .alu_out(alu_out),
    .carry_out(carry_out), .half_carry_out(half_carry_out),
    .overflow_out(overflow_out), .adj_out(adj_out), .a_reg(a_reg),
    .sign_fill(sign_fill), .page_cross(page_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference using whole-number arithmetic on digits
  function automatic void model(input int a, input int b, input int cin, input int op, input int dec,
                                output int out, output int c, output int hc, output int v,
                                output int adj);
    int lo;
    int hi;
    out = 0; c = 0; hc = 0; v = 0; adj = 0;
    case (op)
      0, 1: begin
        lo = (a % 16) + (b % 16) + cin;
        if (op == 0 && dec != 0) begin
          hc = (lo > 9) ? 1 : 0;
          hi = (a / 16) + (b / 16) + hc;
          c  = (hi > 9) ? 1 : 0;
        end else begin
          hc = (lo > 15) ? 1 : 0;
          hi = (a / 16) + (b / 16) + hc;
          c  = (hi > 15) ? 1 : 0;
        end
        out = (hi % 16) * 16 + (lo % 16);
        v = (((a / 128) == (b / 128)) && ((out / 128) != (a / 128))) ? 1 : 0;
      end
      2: out = a & b;
      3: out = a | b;
      4: out = a ^ b;
      5: begin out = cin * 128 + a / 2; c = a % 2; end
      6: out = a;
      7: out = b;
      default: out = 0;
    endcase
    adj = out;
    if (dec != 0 && op == 0)
      adj = (((out / 16) + (c != 0 ? 6 : 0)) % 16) * 16 + ((out % 16) + (hc != 0 ? 6 : 0)) % 16;
    if (dec != 0 && op == 1)
      adj = (((out / 16) + (c != 0 ? 0 : 10)) % 16) * 16 + ((out % 16) + (hc != 0 ? 0 : 10)) % 16;
  endfunction

  function automatic int model_cin();
    case (c_sel)
      2'd0: return 0;
      2'd1: return 1;
      2'd2: return int'(p_carry);
      default: return m_cl;
    endcase
  endfunction

  // Reference state advances on the same edge as the DUT registers
  always @(posedge clk) begin
    int o, c, hc, v, adj;
    if (reset) begin
      m_a = 0; m_b = 0; m_cl = 0;
    end else begin
      model(m_a, m_b, model_cin(), int'(alu_op), int'(dec_en), o, c, hc, v, adj);
      if (ready && a_src != 2'd0) begin
        if (a_src == 2'd1) m_a = int'(a_in);
`ifdef CMOS_BITMASK_EN
        else if (a_src == 2'd3) m_a = 1 << ir_bits;
`endif
        else m_a = 0;
      end
      if (ready && b_load) m_b = int'(b_in);
      m_cl = c;
    end
  end

  // Every-cycle comparison of all outputs against the reference
  always @(negedge clk) begin
    int o, c, hc, v, adj;
    if (!reset) begin
      model(m_a, m_b, model_cin(), int'(alu_op), int'(dec_en), o, c, hc, v, adj);
      chk("alu_out", int'(alu_out), o);
      chk("carry_out", int'(carry_out), c);
      chk("half_carry_out", int'(half_carry_out), hc);
      chk("overflow_out", int'(overflow_out), v);
      chk("adj_out", int'(adj_out), adj);
      chk("a_reg", int'(a_reg), m_a);
      chk("sign_fill", int'(sign_fill), (m_a >= 128) ? 255 : 0);
      chk("page_cross", int'(page_cross), c ^ (m_a / 128));
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    a_src = 2'd1; a_in = a; b_load = 1'b1; b_in = b; ready = 1'b1;
    @(posedge clk); #1;
    a_src = 2'd0; b_load = 1'b0;
  endtask

  task automatic setop(input logic [3:0] op, input logic [1:0] cs, input logic dec);
    alu_op = op; c_sel = cs; dec_en = dec;
    @(negedge clk);
  endtask

  logic [7:0] pair_a [6] = '{8'h00, 8'h09, 8'h45, 8'h99, 8'h80, 8'hF3};
  logic [7:0] pair_b [6] = '{8'h00, 8'h01, 8'h38, 8'h99, 8'hFF, 8'h5A};

  initial begin
    reset = 1'b1; ready = 1'b1; a_src = 2'd0; a_in = 8'h00; b_load = 1'b0; b_in = 8'h00;
    c_sel = 2'd0; p_carry = 1'b0; ir_bits = 3'd0; alu_op = 4'd0; dec_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset a_reg", int'(a_reg), 0);
    chk("reset sign_fill", int'(sign_fill), 0);
    chk("reset alu_out", int'(alu_out), 0);

    load(8'h09, 8'h01); setop(4'd0, 2'd0, 1'b1);
    chk("dec 09+01 alu", int'(alu_out), 'h1A);
    chk("dec 09+01 hc", int'(half_carry_out), 1);
    chk("dec 09+01 c", int'(carry_out), 0);
    chk("dec 09+01 adj", int'(adj_out), 'h10);

    load(8'h99, 8'h01); setop(4'd0, 2'd0, 1'b1);
    chk("dec 99+01 adj", int'(adj_out), 'h00);
    chk("dec 99+01 c", int'(carry_out), 1);
    load(8'h99, 8'h99); setop(4'd0, 2'd1, 1'b1);
    chk("dec 99+99+1 adj", int'(adj_out), 'h99);
    chk("dec 99+99+1 c", int'(carry_out), 1);

    load(8'h10, 8'hFE); setop(4'd1, 2'd1, 1'b1);
    chk("dsbc alu", int'(alu_out), 'h0F);
    chk("dsbc c", int'(carry_out), 1);
    chk("dsbc adj", int'(adj_out), 'h09);
    setop(4'd1, 2'd1, 1'b0);
    chk("bsbc adj", int'(adj_out), 'h0F);

    load(8'h7F, 8'h01); setop(4'd0, 2'd0, 1'b0);
    chk("7F+01 alu", int'(alu_out), 'h80);
    chk("7F+01 v", int'(overflow_out), 1);
    chk("7F+01 c", int'(carry_out), 0);
    load(8'h80, 8'hFF); setop(4'd0, 2'd0, 1'b0);
    chk("80+FF alu", int'(alu_out), 'h7F);
    chk("80+FF v", int'(overflow_out), 1);
    chk("80+FF c", int'(carry_out), 1);
    chk("80+FF page_cross", int'(page_cross), 0);

    load(8'h81, 8'h00); setop(4'd5, 2'd1, 1'b0);
    chk("sr alu", int'(alu_out), 'hC0);
    chk("sr c", int'(carry_out), 1);
    @(posedge clk); #1;
    setop(4'd5, 2'd3, 1'b0);
    chk("sr carry_last alu", int'(alu_out), 'hC0);
    ready = 1'b0; a_src = 2'd1; a_in = 8'h55;
    @(posedge clk); #1;
    a_src = 2'd0; ready = 1'b1;
    @(negedge clk);
    chk("ready hold a_reg", int'(a_reg), 'h81);

    ir_bits = 3'd5; a_src = 2'd3;
    @(posedge clk); #1;
    a_src = 2'd0;
    @(negedge clk);
`ifdef CMOS_BITMASK_EN
    chk("bitmask a_reg", int'(a_reg), 'h20);
`else
    chk("bitmask a_reg", int'(a_reg), 'h00);
`endif
    chk("bitmask sign_fill", int'(sign_fill), 'h00);

    p_carry = 1'b1;
    for (int p = 0; p < 6; p++) begin
      for (int op = 0; op < 10; op++) begin
        for (int d = 0; d < 2; d++) begin
          load(pair_a[p], pair_b[p]);
          setop(4'(op == 9 ? 15 : op), 2'((p + op + d) % 4), d[0]);
        end
      end
    end

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
